acs_unit: RTL and testbench

Add-compare-select stage for the rate-1/2, K=3 (generators 7,5) hard-decision Viterbi decoder. It sits directly downstream of the branch metric unit and consumes its eight 2-bit Hamming branch metrics, one set per received symbol. It keeps the four path metrics and emits one 4-bit survivor decision vector per symbol to the traceback memory. It also reports the current best state and a symbol count.

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/acs_cell.sv | 33 +++
 rtl/acs_unit.sv | 123 ++++++++++++
 tb/tb_acs_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3, rate-1/2 (7,5) hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned PM_W_DEF = 6;

    localparam logic [1:0] S00 = 2'd0;
    localparam logic [1:0] S01 = 2'd1;
    localparam logic [1:0] S10 = 2'd2;
    localparam logic [1:0] S11 = 2'd3;

    // Per next state s: branch index (0 = hd1) and source state of the lower/upper predecessor
    localparam logic [3:0][2:0] LO_BR  = {3'd3, 3'd1, 3'd2, 3'd0};
    localparam logic [3:0][2:0] HI_BR  = {3'd7, 3'd5, 3'd6, 3'd4};
    localparam logic [3:0][1:0] LO_SRC = {S10, S00, S10, S00};
    localparam logic [3:0][1:0] HI_SRC = {S11, S01, S11, S01};

    typedef logic [3:0] dec_t;

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select butterfly half: two candidate sums, pick the smaller (tie -> lower).
// Candidate sums saturate unless ACS_NORM_EN is defined.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = PM_W_DEF
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      hd_a,
    input  logic [1:0]      hd_b,
    output logic [PM_W-1:0] sum,
    output logic            dec
);

    logic [PM_W-1:0] cand_a, cand_b;

`ifdef ACS_NORM_EN
    assign cand_a = pm_a + {{(PM_W-2){1'b0}}, hd_a};
    assign cand_b = pm_b + {{(PM_W-2){1'b0}}, hd_b};
`else
    logic [PM_W:0] sum_a, sum_b;

    assign sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, hd_a};
    assign sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, hd_b};
    assign cand_a = sum_a[PM_W] ? {PM_W{1'b1}} : sum_a[PM_W-1:0];
    assign cand_b = sum_b[PM_W] ? {PM_W{1'b1}} : sum_b[PM_W-1:0];
`endif

    assign dec = (cand_b < cand_a);
    assign sum = dec ? cand_b : cand_a;

endmodule

// File: rtl/acs_unit.sv
// ACS stage: four path metric registers, survivor decisions, best state and symbol count.
// Optional metric normalization is enabled by defining ACS_NORM_EN.
module acs_unit
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W    = PM_W_DEF,
    parameter int unsigned INIT_PM = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [1:0]       hd1,
    input  logic [1:0]       hd2,
    input  logic [1:0]       hd3,
    input  logic [1:0]       hd4,
    input  logic [1:0]       hd5,
    input  logic [1:0]       hd6,
    input  logic [1:0]       hd7,
    input  logic [1:0]       hd8,
    output logic [3:0]       dec,
    output logic             dec_valid,
    output logic [1:0]       best_state,
    output logic [PM_W-1:0]  pm0,
    output logic [PM_W-1:0]  pm1,
    output logic [PM_W-1:0]  pm2,
    output logic [PM_W-1:0]  pm3,
    output logic [CNT_W-1:0] step_cnt,
    output logic             norm_pulse
);

    localparam logic [PM_W-1:0] InitPm = PM_W'(INIT_PM);
    localparam logic [3:0][PM_W-1:0] InitVec = {InitPm, InitPm, InitPm, {PM_W{1'b0}}};

    logic [3:0][PM_W-1:0] pm_q, pm_src, pm_new, pm_d;
    logic [7:0][1:0]      hd;
    dec_t                 dec_q, dec_d;
    logic [1:0]           best_q, best_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 dv_q, norm_q, norm_d;
    logic [PM_W-1:0]      min_pm;

    assign hd = {hd8, hd7, hd6, hd5, hd4, hd3, hd2, hd1};

    // A start coinciding with a symbol runs the ACS from the initial metrics
    assign pm_src = start ? InitVec : pm_q;

    for (genvar s = 0; s < 4; s++) begin : g_cell
        acs_cell #(
            .PM_W (PM_W)
        ) u_cell (
            .pm_a (pm_src[LO_SRC[s]]),
            .pm_b (pm_src[HI_SRC[s]]),
            .hd_a (hd[LO_BR[s]]),
            .hd_b (hd[HI_BR[s]]),
            .sum  (pm_new[s]),
            .dec  (dec_d[s])
        );
    end

    always_comb begin
        best_d = S00;
        min_pm = pm_new[0];
        for (int s = 1; s < 4; s++) begin
            if (pm_new[s] < min_pm) begin
                min_pm = pm_new[s];
                best_d = 2'(s);
            end
        end
    end

`ifdef ACS_NORM_EN
    always_comb begin
        norm_d = pm_new[0][PM_W-1] & pm_new[1][PM_W-1] & pm_new[2][PM_W-1] & pm_new[3][PM_W-1];
        pm_d   = pm_new;
        if (norm_d) begin
            for (int s = 0; s < 4; s++) begin
                pm_d[s][PM_W-1] = 1'b0;
            end
        end
    end
`else
    assign norm_d = 1'b0;
    assign pm_d   = pm_new;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q   <= InitVec;
            dec_q  <= '0;
            best_q <= S00;
            cnt_q  <= '0;
            dv_q   <= 1'b0;
            norm_q <= 1'b0;
        end else if (in_valid) begin
            pm_q   <= pm_d;
            dec_q  <= dec_d;
            best_q <= best_d;
            cnt_q  <= start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            dv_q   <= 1'b1;
            norm_q <= norm_d;
        end else begin
            dv_q   <= 1'b0;
            norm_q <= 1'b0;
            if (start) begin
                pm_q  <= InitVec;
                cnt_q <= '0;
            end
        end
    end

    assign pm0        = pm_q[0];
    assign pm1        = pm_q[1];
    assign pm2        = pm_q[2];
    assign pm3        = pm_q[3];
    assign dec        = dec_q;
    assign dec_valid  = dv_q;
    assign best_state = best_q;
    assign step_cnt   = cnt_q;
    assign norm_pulse = norm_q;

endmodule

// File: tb/tb_acs_unit.sv
// Directed bench for acs_unit; expected values are hand-derived from the trellis.
// Metric growth expectations depend on whether ACS_NORM_EN is defined.
module tb_acs_unit;

    localparam int unsigned PM_W = 6;
    localparam int unsigned CNT_W = 8;

    // {hd1, hd2, ..., hd8} for each received symbol pair
    localparam logic [15:0] RX00 = {2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
    localparam logic [15:0] RX11 = {2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1};
    localparam logic [15:0] RX10 = {2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0};
    localparam logic [15:0] ALL1 = 16'h5555;
    localparam logic [15:0] ALL3 = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [1:0] hd1 = '0, hd2 = '0, hd3 = '0, hd4 = '0, hd5 = '0, hd6 = '0, hd7 = '0, hd8 = '0;
    logic [3:0] dec;
    logic dec_valid, norm_pulse;
    logic [1:0] best_state;
    logic [PM_W-1:0] pm0, pm1, pm2, pm3;
    logic [CNT_W-1:0] step_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acs_unit #(
        .PM_W    (PM_W),
        .INIT_PM (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .hd1        (hd1),
        .hd2        (hd2),
        .hd3        (hd3),
        .hd4        (hd4),
        .hd5        (hd5),
        .hd6        (hd6),
        .hd7        (hd7),
        .hd8        (hd8),
        .dec        (dec),
        .dec_valid  (dec_valid),
        .best_state (best_state),
        .pm0        (pm0),
        .pm1        (pm1),
        .pm2        (pm2),
        .pm3        (pm3),
        .step_cnt   (step_cnt),
        .norm_pulse (norm_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pm(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, ".pm0"}, 32'(pm0), 32'(a));
        chk({tag, ".pm1"}, 32'(pm1), 32'(b));
        chk({tag, ".pm2"}, 32'(pm2), 32'(c));
        chk({tag, ".pm3"}, 32'(pm3), 32'(d));
    endtask

    task automatic chk_out(input string tag, input int d, input int best, input int cnt,
                           input int dv);
        chk({tag, ".dec"}, 32'(dec), 32'(d));
        chk({tag, ".best"}, 32'(best_state), 32'(best));
        chk({tag, ".cnt"}, 32'(step_cnt), 32'(cnt));
        chk({tag, ".dv"}, 32'(dec_valid), 32'(dv));
    endtask

    task automatic sym(input logic [15:0] v, input logic st);
        @(negedge clk);
        in_valid = 1'b1;
        start = st;
        {hd1, hd2, hd3, hd4, hd5, hd6, hd7, hd8} = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start = 1'b0;
        {hd1, hd2, hd3, hd4, hd5, hd6, hd7, hd8} = '0;
    endtask

    task automatic start_only();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk_pm(tag, 0, 4, 4, 4);
        chk_out(tag, 0, 0, 0, 0);
        chk({tag, ".norm"}, 32'(norm_pulse), 32'd0);
    endtask

    initial begin
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        sym(RX00, 1'b0);
        chk_pm("rx00", 0, 5, 2, 5);
        chk_out("rx00", 0, 0, 1, 1);
        chk("rx00.norm", 32'(norm_pulse), 32'd0);
        @(posedge clk);
        #1;
        chk("rx00.dv_drop", 32'(dec_valid), 32'd0);

        start_only();
        chk_pm("start", 0, 4, 4, 4);
        chk("start.cnt", 32'(step_cnt), 32'd0);
        chk("start.dv", 32'(dec_valid), 32'd0);

        sym(RX11, 1'b0);
        chk_pm("rx11", 2, 5, 0, 5);
        chk_out("rx11", 0, 2, 1, 1);
        sym(RX10, 1'b0);
        chk_pm("rx10", 3, 0, 3, 2);
        chk_out("rx10", 0, 1, 2, 1);
        sym(RX11, 1'b0);
        chk_pm("upper_wins", 0, 3, 2, 3);
        chk_out("upper_wins", 4'b1111, 0, 3, 1);

        // Stall: everything holds, no valid strobe
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_pm("hold", 0, 3, 2, 3);
            chk_out("hold", 4'b1111, 0, 3, 0);
        end

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        rst = 1'b1;

        sym(RX11, 1'b0);
        chk_pm("post_rst", 2, 5, 0, 5);
        chk_out("post_rst", 0, 2, 1, 1);
        sym(RX10, 1'b0);
        sym(RX00, 1'b1);
        chk_pm("start_valid", 0, 5, 2, 5);
        chk_out("start_valid", 0, 0, 1, 1);
        start_only();
        chk_pm("start_alone", 0, 4, 4, 4);
        chk("start_alone.cnt", 32'(step_cnt), 32'd0);
        chk("start_alone.dv", 32'(dec_valid), 32'd0);

        // Encoded all-zero stream converges to (0,3,2,3)
        for (int i = 0; i < 10; i++) begin
            sym(RX00, 1'b0);
            chk("zero.pm0", 32'(pm0), 32'd0);
            chk("zero.best", 32'(best_state), 32'd0);
        end
        chk_pm("zero_end", 0, 3, 2, 3);
        chk("zero_end.cnt", 32'(step_cnt), 32'd10);

        // Alternating all-1/all-3 metrics: after step 2m every metric is 4m before wrap/saturation
        start_only();
        for (int i = 1; i <= 32; i++) begin
            sym((i % 2 == 1) ? ALL1 : ALL3, 1'b0);
            if (i == 16) begin
`ifdef ACS_NORM_EN
                chk_pm("norm16", 0, 0, 0, 0);
                chk("norm16.pulse", 32'(norm_pulse), 32'd1);
`else
                chk_pm("grow16", 32, 32, 32, 32);
                chk("grow16.pulse", 32'(norm_pulse), 32'd0);
`endif
                chk_out("step16", 0, 0, 16, 1);
            end
            if (i == 15) begin
                chk_pm("step15", 29, 29, 29, 29);
                chk("step15.pulse", 32'(norm_pulse), 32'd0);
            end
            if (i == 32) begin
`ifdef ACS_NORM_EN
                chk_pm("norm32", 0, 0, 0, 0);
                chk("norm32.pulse", 32'(norm_pulse), 32'd1);
`else
                chk_pm("sat32", 63, 63, 63, 63);
                chk("sat32.pulse", 32'(norm_pulse), 32'd0);
`endif
                chk("step32.cnt", 32'(step_cnt), 32'd32);
            end
        end

        // Counter wrap
        start_only();
        for (int i = 1; i <= 256; i++) begin
            sym(RX00, 1'b0);
            if (i == 255) chk("cnt255", 32'(step_cnt), 32'd255);
        end
        chk("cnt_wrap", 32'(step_cnt), 32'd0);
        chk("cnt_wrap.dv", 32'(dec_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
